// File: rtl/bsg_rr_shared_dff_pkg.sv
// bsg_rr_shared_dff_pkg
//   Types shared by the round-robin shared-register slice.
//   state_e : occupancy of the shared register (EMPTY / FULL).
package bsg_rr_shared_dff_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_rr_shared_dff_pick.sv
// bsg_rr_pick
//   Combinational round-robin picker. Grants the first set request found
//   scanning circularly from last_i+1, so the last winner ranks lowest.
//   reqs_i  : request vector
//   last_i  : index of the previous winner
//   en_i    : grant enable; all outputs are quiet when low
//   grant_o : one-hot grant (zero when nothing granted)
//   idx_o   : encoded index of the granted request
//   v_o     : a grant was issued
module bsg_rr_pick #(
  parameter int num_req_p = 4,
  parameter int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0] reqs_i,
  input  logic [lg_req_lp-1:0] last_i,
  input  logic                 en_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [lg_req_lp-1:0] idx_o,
  output logic                 v_o
);

  always_comb begin
    int k;
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    k       = 0;
    // Offsets 1..num_req_p visit every slot once, ending on last_i itself.
    for (int off = 1; off <= num_req_p; off++) begin
      k = (int'(last_i) + off) % num_req_p;
      if (en_i && !v_o && reqs_i[k]) begin
        v_o        = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = lg_req_lp'(k);
      end
    end
  end

endmodule

// File: rtl/bsg_rr_shared_dff.sv
// bsg_rr_shared_dff
//   Shares one width_p-bit register among num_req_p requesters. Each cycle
//   at most one requester is granted (round-robin) and its word captured;
//   the word is offered downstream with a valid/yumi handshake.
//   clk_i, reset_i : clock, async active-high reset
//   req_v_i        : per-requester valid
//   req_data_i     : packed requester words, k at [k*width_p +: width_p]
//   req_yumi_o     : one-hot/zero, requester's word consumed this cycle
//   v_o, data_o    : shared register valid / contents
//   src_id_o       : requester index that produced data_o
//   yumi_i         : consumer takes data_o (only meaningful while v_o)
module bsg_rr_shared_dff
  import bsg_rr_shared_dff_pkg::*;
#(
  parameter  int width_p   = 13,
  parameter  int num_req_p = 4,
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p-1:0]         req_v_i,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]         req_yumi_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  output logic [lg_req_lp-1:0]         src_id_o,
  input  logic                         yumi_i
);

  state_e               state_q, state_n;
  logic [lg_req_lp-1:0] last_q;
  logic [lg_req_lp-1:0] pick_idx;
  logic                 pick_v;
  logic                 free;

  assign v_o  = (state_q == ST_FULL);
  // Register can take a new word when empty or when it is being drained
  // this same cycle (pass-through refill).
  assign free = ~v_o | yumi_i;

  // Gating with reset keeps req_yumi_o quiet while reset is held, so no
  // requester sees its word consumed during reset.
  bsg_rr_pick #(
    .num_req_p(num_req_p),
    .lg_req_lp(lg_req_lp)
  ) pick (
    .reqs_i (req_v_i),
    .last_i (last_q),
    .en_i   (free & ~reset_i),
    .grant_o(req_yumi_o),
    .idx_o  (pick_idx),
    .v_o    (pick_v)
  );

  // yumi_i while EMPTY falls through to EMPTY: ignored.
  always_comb begin
    state_n = state_q;
    if (pick_v)      state_n = ST_FULL;
    else if (yumi_i) state_n = ST_EMPTY;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_EMPTY;
      data_o   <= '0;
      src_id_o <= '0;
      last_q   <= lg_req_lp'(num_req_p - 1);
    end else begin
      state_q <= state_n;
      if (pick_v) begin
        data_o   <= req_data_i[pick_idx*width_p +: width_p];
        src_id_o <= pick_idx;
        last_q   <= pick_idx;
      end
    end
  end

endmodule
